// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - byte-serial AES inverse SubBytes stage
// Substitutes BYTES_PER_CYCLE bytes per RUN cycle, ascending byte order, start/busy/done handshake.
module inv_sub_bytes #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [127:0] i_initial_state,
  output logic [127:0] o_result_state,
  output logic         o_busy,
  output logic         o_done
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int         N_GROUPS = 16 / BYTES_PER_CYCLE;
  localparam logic [3:0] LAST_GRP = 4'(N_GROUPS - 1);

  // Entry 0 sits in the most significant byte, so byte x lives at offset (255-x)*8 = ~x*8.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   result_q, result_d;
  logic           done_q, done_d;
  logic [127:0]   work_sub;

  // One inverse S-box per lane; the counter selects which byte group feeds the lanes.
  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      work_sub[{4'(int'(cnt_q) * BYTES_PER_CYCLE + l), 3'b000} +: 8] =
        inv_sbox(work_q[{4'(int'(cnt_q) * BYTES_PER_CYCLE + l), 3'b000} +: 8]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          work_d  = i_initial_state;
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = work_sub;
        if (cnt_q == LAST_GRP) begin
          result_d = work_sub;
          done_d   = 1'b1;
          cnt_d    = 4'd0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      work_q   <= 128'h0;
      result_q <= 128'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign o_result_state = result_q;
  assign o_busy         = (state_q == RUN);
  assign o_done         = done_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb/tb_inv_sub_bytes.sv - self-checking bench for inv_sub_bytes
// B=1 instance exercised by vector table and corner sequences; B=4 instance by a back-to-back sweep.
module tb_inv_sub_bytes;

  logic         clk;
  logic         rst;
  logic         i_start1, i_start4;
  logic [127:0] state1, state4;
  logic [127:0] o_result1, o_result4;
  logic         o_busy1, o_busy4, o_done1, o_done4;

  int n_checks = 0;
  int n_fail   = 0;

  inv_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(i_start1), .i_initial_state(state1),
    .o_result_state(o_result1), .o_busy(o_busy1), .o_done(o_done1)
  );

  inv_sub_bytes #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(i_start4), .i_initial_state(state4),
    .o_result_state(o_result4), .o_busy(o_busy4), .o_done(o_done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] inv_ref [256];
  int         n_done, lat, extra_busy, prev, blk_in, blk_out;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: forward S-box from GF(2^8) inversion plus affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int z = 1; z < 256; z++) if (gmul(x, 8'(z)) == 8'h01) v = 8'(z);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] mk_blk(input int j);
    logic [127:0] s;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(j * 16 + k);
    return s;
  endfunction

  function automatic logic [127:0] exp_blk(input int j);
    logic [127:0] s;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = inv_ref[j * 16 + k];
    return s;
  endfunction

  task automatic start_b1(input logic [127:0] st);
    @(negedge clk);
    i_start1 = 1'b1;
    state1   = st;
    @(posedge clk);
    #1;
    i_start1 = 1'b0;
    state1   = ~st;
  endtask

  task automatic run_b1(input string nm, input logic [127:0] st, input logic [127:0] exp);
    int l, busy_cnt;
    l = -1;
    busy_cnt = 0;
    start_b1(st);
    for (int k = 1; k <= 40 && l < 0; k++) begin
      @(negedge clk);
      if (o_done1) begin
        l = k - 1;
        chk({nm, "_busy_at_done"}, 128'(o_busy1), 128'h0);
      end else if (o_busy1) begin
        busy_cnt++;
      end
    end
    chk({nm, "_latency"}, l, 16);
    chk({nm, "_busy_cycles"}, busy_cnt, 16);
    chk({nm, "_result"}, o_result1, exp);
    @(negedge clk);
    chk({nm, "_done_clears"}, 128'(o_done1), 128'h0);
    chk({nm, "_result_holds"}, o_result1, exp);
  endtask

  initial begin
    for (int y = 0; y < 256; y++) inv_ref[fwd_sbox(8'(y))] = 8'(y);

    vecs[0] = '{"all63", {16{8'h63}}, 128'h0};
    vecs[1] = '{"order", 128'h636363636363636363636363ed167c00,
                         128'h00000000000000000000000053ff0152};
    vecs[2] = '{"all01", {16{8'h01}}, {16{8'h09}}};
    vecs[3] = '{"allff", {16{8'hff}}, {16{8'h7d}}};
    vecs[4] = '{"all00", {16{8'h00}}, {16{8'h52}}};

    // Reset with start asserted and random data on both instances.
    rst      = 1'b1;
    i_start1 = 1'b1;
    i_start4 = 1'b1;
    state1   = {$urandom, $urandom, $urandom, $urandom};
    state4   = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result1", o_result1, 128'h0);
    chk("rst_busy1", 128'(o_busy1), 128'h0);
    chk("rst_done1", 128'(o_done1), 128'h0);
    chk("rst_result4", o_result4, 128'h0);
    chk("rst_busy4", 128'(o_busy4), 128'h0);
    chk("rst_done4", 128'(o_done4), 128'h0);
    rst      = 1'b0;
    i_start1 = 1'b0;
    i_start4 = 1'b0;
    @(negedge clk);

    // Start while busy must be ignored.
    start_b1({16{8'h01}});
    n_done = 0; lat = -1; extra_busy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        i_start1 = 1'b1;
        state1   = 128'h0;
      end else if (k == 6) begin
        i_start1 = 1'b0;
      end
      if (o_done1) begin
        n_done++;
        if (lat < 0) lat = k - 1;
      end
      if (k >= 18 && o_busy1) extra_busy++;
    end
    chk("rej_done_count", n_done, 1);
    chk("rej_latency", lat, 16);
    chk("rej_result", o_result1, {16{8'h09}});
    chk("rej_no_second_run", extra_busy, 0);

    for (int i = 0; i < 5; i++) run_b1(vecs[i].nm, vecs[i].st, vecs[i].exp);

    // Reset at cycle 8 of RUN aborts the transform and clears the nonzero prior result.
    start_b1({16{8'h63}});
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_result", o_result1, 128'h0);
    chk("abort_busy", 128'(o_busy1), 128'h0);
    chk("abort_done", 128'(o_done1), 128'h0);
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (o_done1 || o_busy1) n_done++;
    end
    chk("abort_no_activity", n_done, 0);
    run_b1("after_abort", vecs[1].st, vecs[1].exp);

    // B=4: start held high, 16 blocks sweeping all byte values.
    prev = -1; blk_in = 0; blk_out = 0;
    for (int i = 0; i < 200 && blk_out < 16; i++) begin
      @(negedge clk);
      if (o_done4) begin
        chk($sformatf("b4_blk%0d", blk_out), o_result4, exp_blk(blk_out));
        if (blk_out == 0) chk("b4_first_latency", i, 5);
        else chk($sformatf("b4_period%0d", blk_out), i - prev, 5);
        prev = i;
        blk_out++;
      end
      if (!o_busy4) begin
        if (blk_in < 16) begin
          i_start4 = 1'b1;
          state4   = mk_blk(blk_in);
          blk_in++;
        end else begin
          i_start4 = 1'b0;
        end
      end
    end
    i_start4 = 1'b0;
    chk("b4_blocks_done", blk_out, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
